m_split_seq: RTL and testbench

Sequencer for the memory-stage input-alignment path. It accepts one access request at a time, sequences the TLB lookup, and drives the TLB-fill handshake on a miss. It then issues the low half (part 0) and, for line-crossing accesses, the high half (part 1) to the cache banks. It finishes by returning a completion with a fault code. It sits between the M-stage request source and the align/TLB/cache datapath, and owns the `needP1` split sequencing.

---
 rtl/m_split_seq.sv | 172 +++++++++++++++++
 tb/tb_m_split_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_split_seq.sv
// m_split_seq
// -----------------------------------------------------------------------------
// Memory-stage split-access sequencer. Accepts one request at a time, runs the
// TLB lookup (with fill handshake and bounded retries on a miss), issues part 0
// and, for line-crossing accesses, part 1 to the cache banks, then returns a
// completion carrying the request tag and a fault code.
//
// Ports:
//   clk          rising-edge clock
//   clr          asynchronous active-low reset
//   req_valid    request present           req_ready   accepting (IDLE only)
//   req_needP1   part 1 required           req_id      7-bit request tag
//   tlb_hit / tlb_miss / prot_exc          TLB results, sampled in LOOKUP
//   miss_req     TLB fill request          fill_done   fill complete pulse
//   p0_go/p1_go  issue part 0 / part 1     cache_ack   cache took the part
//   done_valid   completion present        done_ready  consumer takes it
//   done_fault   00 ok, 01 prot, 10 retry exhausted, 11 ack timeout
//   done_id      tag of the completing request
// -----------------------------------------------------------------------------
module m_split_seq #(
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_needP1,
    input  logic [6:0] req_id,
    input  logic       tlb_hit,
    input  logic       tlb_miss,
    input  logic       prot_exc,
    output logic       miss_req,
    input  logic       fill_done,
    output logic       p0_go,
    output logic       p1_go,
    input  logic       cache_ack,
    output logic       done_valid,
    input  logic       done_ready,
    output logic [1:0] done_fault,
    output logic [6:0] done_id
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MISS   = 3'd2,
        S_ISSUE0 = 3'd3,
        S_ISSUE1 = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);
    localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);

    localparam logic [1:0] F_OK    = 2'b00;
    localparam logic [1:0] F_PROT  = 2'b01;
    localparam logic [1:0] F_RETRY = 2'b10;
    localparam logic [1:0] F_TMO   = 2'b11;

    state_t     state_reg, state_next;
    logic       needp1_reg, needp1_next;
    logic [6:0] id_reg, id_next;
    logic [1:0] retry_reg, retry_next;
    logic [7:0] tmo_reg, tmo_next;
    logic [1:0] fault_next;

    // Next-state and counter logic. fault_next is only consumed on the
    // transition into RESP.
    always_comb begin
        state_next  = state_reg;
        needp1_next = needp1_reg;
        id_next     = id_reg;
        retry_next  = retry_reg;
        tmo_next    = tmo_reg;
        fault_next  = F_OK;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    id_next     = req_id;
                    needp1_next = req_needP1;
                    retry_next  = 2'd0;
                    state_next  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (prot_exc) begin
                    fault_next = F_PROT;
                    state_next = S_RESP;
                end else if (tlb_miss) begin
                    if (retry_reg == RETRY_LIMIT) begin
                        fault_next = F_RETRY;
                        state_next = S_RESP;
                    end else begin
                        retry_next = retry_reg + 2'd1;
                        state_next = S_MISS;
                    end
                end else if (tlb_hit) begin
                    tmo_next   = 8'd0;
                    state_next = S_ISSUE0;
                end
            end
            S_MISS: begin
                if (fill_done) begin
                    state_next = S_LOOKUP;
                end
            end
            S_ISSUE0, S_ISSUE1: begin
                // An ack in the cycle the timeout would fire still wins.
                if (cache_ack) begin
                    if (state_reg == S_ISSUE0 && needp1_reg) begin
                        tmo_next   = 8'd0;
                        state_next = S_ISSUE1;
                    end else begin
                        fault_next = F_OK;
                        state_next = S_RESP;
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    fault_next = F_TMO;
                    state_next = S_RESP;
                end else begin
                    tmo_next = tmo_reg + 8'd1;
                end
            end
            S_RESP: begin
                if (done_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, counters and registered Moore outputs. Outputs are decoded from
    // state_next so they line up with the state they describe; the async
    // reset drops every go/req output the moment clr falls.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg  <= S_IDLE;
            needp1_reg <= 1'b0;
            id_reg     <= 7'd0;
            retry_reg  <= 2'd0;
            tmo_reg    <= 8'd0;
            req_ready  <= 1'b1;
            miss_req   <= 1'b0;
            p0_go      <= 1'b0;
            p1_go      <= 1'b0;
            done_valid <= 1'b0;
            done_fault <= F_OK;
            done_id    <= 7'd0;
        end else begin
            state_reg  <= state_next;
            needp1_reg <= needp1_next;
            id_reg     <= id_next;
            retry_reg  <= retry_next;
            tmo_reg    <= tmo_next;
            req_ready  <= (state_next == S_IDLE);
            miss_req   <= (state_next == S_MISS);
            p0_go      <= (state_next == S_ISSUE0);
            p1_go      <= (state_next == S_ISSUE1);
            done_valid <= (state_next == S_RESP);
            // Completion fields load once on entry to RESP and then hold.
            if (state_reg != S_RESP && state_next == S_RESP) begin
                done_fault <= fault_next;
                done_id    <= id_reg;
            end
        end
    end

endmodule

// File: tb/tb_m_split_seq.sv
module tb_m_split_seq;

    logic       clk;
    logic       clr;
    logic       req_valid;
    logic       req_ready;
    logic       req_needP1;
    logic [6:0] req_id;
    logic       tlb_hit;
    logic       tlb_miss;
    logic       prot_exc;
    logic       miss_req;
    logic       fill_done;
    logic       p0_go;
    logic       p1_go;
    logic       cache_ack;
    logic       done_valid;
    logic       done_ready;
    logic [1:0] done_fault;
    logic [6:0] done_id;

    int errors = 0;
    int checks = 0;

    // Running totals sampled on the falling edge; the sequence snapshots them.
    int p0_total   = 0;
    int p1_total   = 0;
    int miss_total = 0;
    int done_total = 0;
    int both_total = 0;

    int p0_s, p1_s, miss_s, done_s;

    m_split_seq #(
        .TIMEOUT  (4),
        .MAX_RETRY(2)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_needP1(req_needP1),
        .req_id    (req_id),
        .tlb_hit   (tlb_hit),
        .tlb_miss  (tlb_miss),
        .prot_exc  (prot_exc),
        .miss_req  (miss_req),
        .fill_done (fill_done),
        .p0_go     (p0_go),
        .p1_go     (p1_go),
        .cache_ack (cache_ack),
        .done_valid(done_valid),
        .done_ready(done_ready),
        .done_fault(done_fault),
        .done_id   (done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (p0_go) p0_total++;
        if (p1_go) p1_total++;
        if (miss_req) miss_total++;
        if (done_valid) done_total++;
        if (p0_go && p1_go) both_total++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        p0_s   = p0_total;
        p1_s   = p1_total;
        miss_s = miss_total;
        done_s = done_total;
    endtask

    initial begin
        clr = 1'b0; req_valid = 1'b0; req_needP1 = 1'b0; req_id = 7'd0;
        tlb_hit = 1'b0; tlb_miss = 1'b0; prot_exc = 1'b0; fill_done = 1'b0;
        cache_ack = 1'b0; done_ready = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_miss_req", 32'(miss_req), 32'd0);
        chk("rst_p0_go", 32'(p0_go), 32'd0);
        chk("rst_p1_go", 32'(p1_go), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_done_fault", 32'(done_fault), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        clr = 1'b1;
        tick();

        // stray ack/fill in IDLE must have no effect
        cache_ack = 1'b1; fill_done = 1'b1;
        tick();
        cache_ack = 1'b0; fill_done = 1'b0;
        chk("stray_req_ready", 32'(req_ready), 32'd1);
        chk("stray_p0_go", 32'(p0_go), 32'd0);
        chk("stray_miss_req", 32'(miss_req), 32'd0);
        $display("tx stray ack/fill in IDLE");

        // ---------------- split hit, id 0x2A ----------------
        snap();
        req_valid = 1'b1; req_needP1 = 1'b1; req_id = 7'h2A;
        tick();                                   // T+1 LOOKUP
        req_valid = 1'b0; tlb_hit = 1'b1;
        chk("split_t1_req_ready", 32'(req_ready), 32'd0);
        chk("split_t1_p0_go", 32'(p0_go), 32'd0);
        tick();                                   // T+2 ISSUE0
        tlb_hit = 1'b0; cache_ack = 1'b1;
        chk("split_t2_p0_go", 32'(p0_go), 32'd1);
        chk("split_t2_p1_go", 32'(p1_go), 32'd0);
        tick();                                   // T+3 ISSUE1
        chk("split_t3_p1_go", 32'(p1_go), 32'd1);
        chk("split_t3_p0_go", 32'(p0_go), 32'd0);
        chk("split_t3_done_valid", 32'(done_valid), 32'd0);
        tick();                                   // T+4 RESP
        cache_ack = 1'b0;
        chk("split_t4_done_valid", 32'(done_valid), 32'd1);
        chk("split_t4_fault", 32'(done_fault), 32'd0);
        chk("split_t4_id", 32'(done_id), 32'h2A);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        chk("split_done_one_cycle", 32'(done_valid), 32'd0);
        chk("split_req_ready_back", 32'(req_ready), 32'd1);
        $display("tx split hit id=2a fault=%0d", done_fault);

        // ---------------- unsplit, ack 3 cycles after p0_go ----------------
        snap();
        req_valid = 1'b1; req_needP1 = 1'b0; req_id = 7'h11;
        tick();
        req_valid = 1'b0; tlb_hit = 1'b1;
        tick();                                   // ISSUE0 cycle 1
        tlb_hit = 1'b0;
        tick(); tick(); tick();                   // ISSUE0 cycle 4
        chk("delay_p0_still_high", 32'(p0_go), 32'd1);
        cache_ack = 1'b1;                         // ack on the timeout cycle
        tick();
        cache_ack = 1'b0;
        chk("delay_done_valid", 32'(done_valid), 32'd1);
        chk("delay_fault", 32'(done_fault), 32'd0);
        chk("delay_id", 32'(done_id), 32'h11);
        chk("delay_p0_cycles", 32'(p0_total - p0_s), 32'd4);
        chk("delay_p1_cycles", 32'(p1_total - p1_s), 32'd0);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        $display("tx unsplit delayed ack id=11 fault=%0d", done_fault);

        // ---------------- miss then hit ----------------
        snap();
        req_valid = 1'b1; req_needP1 = 1'b0; req_id = 7'h33;
        tick();
        req_valid = 1'b0; tlb_miss = 1'b1;
        tick();                                   // MISS cycle 1
        tlb_miss = 1'b0;
        chk("miss_req_high", 32'(miss_req), 32'd1);
        tick(); tick(); tick(); tick(); tick();    // MISS cycle 6
        fill_done = 1'b1;
        tick();                                   // LOOKUP
        fill_done = 1'b0; tlb_hit = 1'b1;
        chk("miss_req_dropped", 32'(miss_req), 32'd0);
        tick();                                   // ISSUE0
        tlb_hit = 1'b0; cache_ack = 1'b1;
        chk("miss_p0_go", 32'(p0_go), 32'd1);
        tick();
        cache_ack = 1'b0;
        chk("miss_done_valid", 32'(done_valid), 32'd1);
        chk("miss_fault", 32'(done_fault), 32'd0);
        chk("miss_id", 32'(done_id), 32'h33);
        chk("miss_req_cycles", 32'(miss_total - miss_s), 32'd6);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        $display("tx miss-then-hit id=33 fault=%0d", done_fault);

        // ---------------- retry exhaustion ----------------
        snap();
        req_valid = 1'b1; req_needP1 = 1'b1; req_id = 7'h44;
        tick();
        req_valid = 1'b0; tlb_miss = 1'b1;
        tick();                                   // MISS #1
        chk("retry_miss1", 32'(miss_req), 32'd1);
        fill_done = 1'b1;
        tick();                                   // LOOKUP
        fill_done = 1'b0;
        tick();                                   // MISS #2
        chk("retry_miss2", 32'(miss_req), 32'd1);
        fill_done = 1'b1;
        tick();                                   // LOOKUP
        fill_done = 1'b0;
        tick();                                   // RESP
        tlb_miss = 1'b0;
        chk("retry_done_valid", 32'(done_valid), 32'd1);
        chk("retry_fault", 32'(done_fault), 32'd2);
        chk("retry_id", 32'(done_id), 32'h44);
        chk("retry_fill_count", 32'(miss_total - miss_s), 32'd2);
        chk("retry_no_go", 32'((p0_total - p0_s) + (p1_total - p1_s)), 32'd0);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        $display("tx retry exhausted id=44 fault=%0d", done_fault);

        // ---------------- protection + backpressure ----------------
        snap();
        req_valid = 1'b1; req_needP1 = 1'b0; req_id = 7'h55;
        tick();
        req_valid = 1'b0; tlb_miss = 1'b1; prot_exc = 1'b1;
        tick();                                   // RESP
        tlb_miss = 1'b0; prot_exc = 1'b0;
        req_valid = 1'b1; req_id = 7'h0F;         // must be ignored
        chk("prot_done_valid", 32'(done_valid), 32'd1);
        chk("prot_fault", 32'(done_fault), 32'd1);
        chk("prot_no_miss", 32'(miss_total - miss_s), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_done_valid", 32'(done_valid), 32'd1);
            chk("bp_fault", 32'(done_fault), 32'd1);
            chk("bp_id", 32'(done_id), 32'h55);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0; done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        chk("bp_released", 32'(done_valid), 32'd0);
        tick();
        chk("bp_idle_stays", 32'(req_ready), 32'd1);
        $display("tx protection id=55 fault=%0d", done_fault);

        // ---------------- ack timeout ----------------
        snap();
        req_valid = 1'b1; req_needP1 = 1'b0; req_id = 7'h66;
        tick();
        req_valid = 1'b0; tlb_hit = 1'b1;
        tick();                                   // ISSUE0 cycle 1
        tlb_hit = 1'b0;
        tick(); tick(); tick(); tick();           // RESP
        chk("tmo_done_valid", 32'(done_valid), 32'd1);
        chk("tmo_fault", 32'(done_fault), 32'd3);
        chk("tmo_id", 32'(done_id), 32'h66);
        chk("tmo_p0_go_low", 32'(p0_go), 32'd0);
        chk("tmo_p0_cycles", 32'(p0_total - p0_s), 32'd4);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        $display("tx timeout id=66 fault=%0d", done_fault);

        // ---------------- clr during ISSUE1 ----------------
        snap();
        req_valid = 1'b1; req_needP1 = 1'b1; req_id = 7'h77;
        tick();
        req_valid = 1'b0; tlb_hit = 1'b1;
        tick();                                   // ISSUE0
        tlb_hit = 1'b0; cache_ack = 1'b1;
        tick();                                   // ISSUE1
        cache_ack = 1'b0;
        chk("clr_p1_go_before", 32'(p1_go), 32'd1);
        #2;
        clr = 1'b0;
        #1;
        chk("clr_p1_go_drop", 32'(p1_go), 32'd0);
        chk("clr_req_ready", 32'(req_ready), 32'd1);
        tick();
        clr = 1'b1;
        tick(); tick();
        chk("clr_after_req_ready", 32'(req_ready), 32'd1);
        chk("clr_no_done", 32'(done_total - done_s), 32'd0);
        $display("tx clr abandon id=77");

        chk("never_both_go", 32'(both_total), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
